// File: rtl/ym3438_pg_increment_if.sv
// ym3438_pg_increment_if: slot-multiplexed bus between the detune/timing sources and the phase generator.
interface ym3438_pg_increment_if;
    logic        c1;
    logic        c2;
    logic [10:0] fnum;
    logic [2:0]  block;
    logic        dt_sign;
    logic [4:0]  dt_value;
    logic [3:0]  multi;
    logic        pg_reset;
    logic [19:0] inc_out;
    logic [9:0]  phase_out;
    modport master (
        output c1, c2, fnum, block, dt_sign, dt_value, multi, pg_reset,
        input  inc_out, phase_out
    );
    modport slave (
        input  c1, c2, fnum, block, dt_sign, dt_value, multi, pg_reset,
        output inc_out, phase_out
    );
endinterface

// File: rtl/ym3438_pg_increment.sv
// ym3438_pg_increment: per-slot phase increment (block/fnum, detune, MUL) and 24-slot phase accumulator ring.
module ym3438_pg_increment #(
    parameter int SLOTS   = 24,
    parameter int PHASE_W = 20
) (
    input logic                   MCLK,
    input logic                   IC_n,
    ym3438_pg_increment_if.slave  bus
);
    logic [10:0]                     fnum_q, fnum_d;
    logic [2:0]                      block_q, block_d;
    logic                            dt_sign_q, dt_sign_d;
    logic [4:0]                      dt_value_q, dt_value_d;
    logic [3:0]                      multi_q, multi_d;
    logic                            pg_reset_q, pg_reset_d;
    logic [16:0]                     base_q, base_d;
    logic [16:0]                     det_q, det_d;
    logic [PHASE_W-1:0]              inc_q, inc_d;
    logic [SLOTS-1:0][PHASE_W-1:0]   ring_q, ring_d;
    logic [9:0]                      phase_q, phase_d;
    logic [PHASE_W-1:0]              prod;
    logic [PHASE_W-1:0]              sum;

    // c1 fills the master latches; c2 advances every stage and the ring by one slot
    always_comb begin
        prod       = PHASE_W'(det_q) * PHASE_W'(multi_q);
        sum        = pg_reset_q ? '0 : ring_q[0] + inc_q;
        fnum_d     = bus.c1 ? bus.fnum : fnum_q;
        block_d    = bus.c1 ? bus.block : block_q;
        dt_sign_d  = bus.c1 ? bus.dt_sign : dt_sign_q;
        dt_value_d = bus.c1 ? bus.dt_value : dt_value_q;
        multi_d    = bus.c1 ? bus.multi : multi_q;
        pg_reset_d = bus.c1 ? bus.pg_reset : pg_reset_q;
        base_d     = bus.c2 ? 17'(({7'b0, fnum_q} << block_q) >> 1) : base_q;
        det_d      = bus.c2 ? (dt_sign_q ? base_q - 17'(dt_value_q) : base_q + 17'(dt_value_q)) : det_q;
        inc_d      = bus.c2 ? (multi_q == 4'd0 ? PHASE_W'(det_q[16:1]) : prod) : inc_q;
        ring_d     = bus.c2 ? {sum, ring_q[SLOTS-1:1]} : ring_q;
        phase_d    = bus.c2 ? sum[PHASE_W-1 -: 10] : phase_q;
    end

    always_ff @(posedge MCLK or negedge IC_n) begin
        if (!IC_n) begin
            fnum_q     <= '0;
            block_q    <= '0;
            dt_sign_q  <= 1'b0;
            dt_value_q <= '0;
            multi_q    <= '0;
            pg_reset_q <= 1'b0;
            base_q     <= '0;
            det_q      <= '0;
            inc_q      <= '0;
            ring_q     <= '0;
            phase_q    <= '0;
        end else begin
            fnum_q     <= fnum_d;
            block_q    <= block_d;
            dt_sign_q  <= dt_sign_d;
            dt_value_q <= dt_value_d;
            multi_q    <= multi_d;
            pg_reset_q <= pg_reset_d;
            base_q     <= base_d;
            det_q      <= det_d;
            inc_q      <= inc_d;
            ring_q     <= ring_d;
            phase_q    <= phase_d;
        end
    end

    assign bus.inc_out   = inc_q;
    assign bus.phase_out = phase_q;
endmodule

// File: tb/tb_ym3438_pg_increment.sv
// tb_ym3438_pg_increment: random and directed slot streams checked against a per-step arithmetic model.
module tb_ym3438_pg_increment;
    localparam int SLOTS = 24;
    localparam int OFF   = 3;
    localparam int NS    = 300;

    logic MCLK = 1'b0;
    logic IC_n = 1'b0;
    ym3438_pg_increment_if bus();
    ym3438_pg_increment #(.SLOTS(SLOTS), .PHASE_W(20)) dut (.MCLK(MCLK), .IC_n(IC_n), .bus(bus));

    always #5 MCLK = ~MCLK;

    int n_chk  = 0;
    int n_fail = 0;
    int f_a[NS], b_a[NS], ds_a[NS], dv_a[NS], m_a[NS], r_a[NS];
    int ring[$];
    logic [19:0] tp_inc[4] = '{20'h04006, 20'h00FFE, 20'h1FFFF, 20'hDFD6C};

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // arrays are indexed by step+OFF; steps before 0 stay zero, matching the cleared pipeline
    function automatic int inc_of(int k);
        int base, det, m;
        base = (f_a[k+OFF] << b_a[k+OFF]) / 2;
        det  = ds_a[k+1+OFF] != 0 ? base - dv_a[k+1+OFF] : base + dv_a[k+1+OFF];
        det  = det & 'h1FFFF;
        m    = m_a[k+2+OFF];
        return m == 0 ? det / 2 : (det * m) % (1 << 20);
    endfunction

    function automatic void place(int k, int f, int b, int ds, int dv, int m, int r);
        f_a[k+OFF]    = f;
        b_a[k+OFF]    = b;
        ds_a[k+1+OFF] = ds;
        dv_a[k+1+OFF] = dv;
        m_a[k+2+OFF]  = m;
        r_a[k+3+OFF]  = r;
    endfunction

    function automatic void clear_model();
        for (int i = 0; i < NS; i++) begin
            f_a[i] = 0; b_a[i] = 0; ds_a[i] = 0; dv_a[i] = 0; m_a[i] = 0; r_a[i] = 0;
        end
        ring.delete();
        for (int i = 0; i < SLOTS; i++) ring.push_back(0);
    endfunction

    function automatic void fill_random(int lo, int hi);
        for (int s = lo; s <= hi; s++) begin
            f_a[s+OFF]  = int'($urandom_range(0, 2047));
            b_a[s+OFF]  = int'($urandom_range(0, 7));
            ds_a[s+OFF] = int'($urandom_range(0, 1));
            dv_a[s+OFF] = int'($urandom_range(0, 31));
            m_a[s+OFF]  = int'($urandom_range(0, 15));
            r_a[s+OFF]  = ($urandom_range(0, 7) == 0) ? 1 : 0;
        end
    endfunction

    task automatic scramble();
        bus.fnum     = 11'($urandom);
        bus.block    = 3'($urandom);
        bus.dt_sign  = 1'($urandom);
        bus.dt_value = 5'($urandom);
        bus.multi    = 4'($urandom);
        bus.pg_reset = 1'($urandom);
    endtask

    task automatic run_step(int s);
        int h, nw;
        bus.fnum     = 11'(f_a[s+OFF]);
        bus.block    = 3'(b_a[s+OFF]);
        bus.dt_sign  = 1'(ds_a[s+OFF]);
        bus.dt_value = 5'(dv_a[s+OFF]);
        bus.multi    = 4'(m_a[s+OFF]);
        bus.pg_reset = 1'(r_a[s+OFF]);
        bus.c1 = 1'b1;
        @(posedge MCLK); #1 bus.c1 = 1'b0;
        scramble();
        if ($urandom_range(0, 3) == 0) begin
            @(posedge MCLK); #1;
        end
        bus.c2 = 1'b1;
        @(posedge MCLK); #1 bus.c2 = 1'b0;
        h  = ring.pop_front();
        nw = r_a[s+OFF] != 0 ? 0 : (h + inc_of(s - 3)) % (1 << 20);
        ring.push_back(nw);
        chk("inc", 32'(bus.inc_out), 32'(inc_of(s - 2)));
        chk("phase", 32'(bus.phase_out), 32'(nw >> 10));
    endtask

    initial begin
        bus.c1 = 1'b0;
        bus.c2 = 1'b0;
        scramble();
        repeat (3) @(posedge MCLK);
        #1;
        chk("rst_inc", 32'(bus.inc_out), 32'h0);
        chk("rst_phase", 32'(bus.phase_out), 32'h0);
        IC_n = 1'b1;

        clear_model();
        place(0, 'h400, 4, 0, 3, 2, 0);
        place(1, 'h400, 4, 1, 3, 0, 0);
        place(2, 0, 0, 1, 1, 1, 0);
        place(3, 'h7FF, 7, 0, 20, 15, 0);
        place(5, 'h554, 7, 0, 0, 4, 0);
        place(29, 'h554, 7, 0, 0, 4, 1);
        for (int p = 2; p < 6; p++) place(24 * p + 5, 'h554, 7, 0, 0, 4, 0);
        for (int p = 1; p < 6; p++) place(24 * p, 'h400, 7, 0, 0, 4, 0);
        for (int p = 0; p < 6; p++) place(24 * p + 6, 'h123, 3, 0, 5, 3, 0);
        fill_random(144, 239);
        for (int s = 0; s < 240; s++) begin
            run_step(s);
            if (s >= 2 && s <= 5) chk("tp_inc", 32'(bus.inc_out), 32'(tp_inc[s-2]));
            if (s == 8 || s == 56) chk("keyon_acc", 32'(bus.phase_out), 32'h155);
            if (s == 32) chk("keyon_clr", 32'(bus.phase_out), 32'h0);
        end

        // asynchronous reset lands between a c1 and its c2
        scramble();
        bus.c1 = 1'b1;
        @(posedge MCLK); #1 bus.c1 = 1'b0;
        #2 IC_n = 1'b0;
        #1;
        chk("async_inc", 32'(bus.inc_out), 32'h0);
        chk("async_phase", 32'(bus.phase_out), 32'h0);
        for (int i = 0; i < 3; i++) begin
            scramble();
            bus.c1 = 1'b1;
            @(posedge MCLK); #1 bus.c1 = 1'b0;
            bus.c2 = 1'b1;
            @(posedge MCLK); #1 bus.c2 = 1'b0;
            chk("hold_inc", 32'(bus.inc_out), 32'h0);
            chk("hold_phase", 32'(bus.phase_out), 32'h0);
        end
        IC_n = 1'b1;

        clear_model();
        fill_random(0, 71);
        for (int s = 0; s < 72; s++) run_step(s);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
